// File: rtl/alu.sv
// 32-bit integer ALU for the single-cycle CPU datapath.
// Logic, add/sub, compare and shift results are combinational. MULT (and DIV,
// when built) also load the HI/LO registers on the rising clock edge.
// The LO register drives the lo port.
// Optional feature macro: ALU_DIV_EN builds the signed divider for opcode 1100.
// Without it, 1100 decodes as an undefined opcode.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       ALUCtr,
  output logic [WIDTH-1:0] ALURes,
  output logic [WIDTH-1:0] lo,
  output logic             zero
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MULT = 4'b1011;
  localparam logic [3:0] OP_DIV  = 4'b1100;
  localparam logic [3:0] OP_MFHI = 4'b1101;
  localparam logic [3:0] OP_MFLO = 4'b1110;

  logic signed [WIDTH-1:0]   a_s;
  logic signed [WIDTH-1:0]   b_s;
  logic signed [2*WIDTH-1:0] a_ext;
  logic signed [2*WIDTH-1:0] b_ext;
  logic signed [2*WIDTH-1:0] prod;
  logic [SHW-1:0]            shamt;
  logic [WIDTH-1:0]          hi_q;
  logic [WIDTH-1:0]          lo_q;
  logic                      mult_op;

  assign a_s   = $signed(in1);
  assign b_s   = $signed(in2);
  // Sign-extend both operands so the truncated 2W-bit product is the exact signed product.
  assign a_ext = {{WIDTH{in1[WIDTH-1]}}, in1};
  assign b_ext = {{WIDTH{in2[WIDTH-1]}}, in2};
  assign prod  = a_ext * b_ext;
  // Only the low bits of A steer the shifter; the upper bits are ignored.
  assign shamt = in1[SHW-1:0];

  assign mult_op = (ALUCtr == OP_MULT);

`ifdef ALU_DIV_EN
  logic                  div_op;
  logic [2*WIDTH-1:0]    divrem;
  logic [WIDTH-1:0]      div_quo;
  logic [WIDTH-1:0]      div_rem;

  // Signed divide returning {remainder, quotient}. The quotient truncates toward
  // zero and the remainder follows the dividend's sign. Dividing by zero gives an
  // all-ones quotient and returns the dividend as the remainder. The most-negative
  // value divided by -1 falls out of the magnitude datapath as quotient = MIN and
  // remainder = 0, so it needs no special case.
  function automatic logic [2*WIDTH-1:0] sdivrem(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] ua;
    logic [WIDTH-1:0] ub;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH:0]   r;
    if (b == '0) begin
      return {a, {WIDTH{1'b1}}};
    end
    ua = a[WIDTH-1] ? (~a + 1'b1) : a;
    ub = b[WIDTH-1] ? (~b + 1'b1) : b;
    r  = '0;
    q  = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      r = {r[WIDTH-1:0], ua[i]};
      if (r >= {1'b0, ub}) begin
        r    = r - {1'b0, ub};
        q[i] = 1'b1;
      end
    end
    r_out = r[WIDTH-1:0];
    if (a[WIDTH-1] ^ b[WIDTH-1]) begin
      q = ~q + 1'b1;
    end
    if (a[WIDTH-1]) begin
      r_out = ~r_out + 1'b1;
    end
    return {r_out, q};
  endfunction

  assign div_op  = (ALUCtr == OP_DIV);
  assign divrem  = sdivrem(in1, in2);
  assign div_quo = divrem[WIDTH-1:0];
  assign div_rem = divrem[2*WIDTH-1:WIDTH];
`endif

  // Combinational result mux; undefined or disabled opcodes produce zero.
  always_comb begin
    ALURes = '0;
    case (ALUCtr)
      OP_AND:  ALURes = in1 & in2;
      OP_OR:   ALURes = in1 | in2;
      OP_ADD:  ALURes = in1 + in2;
      OP_XOR:  ALURes = in1 ^ in2;
      OP_SLTU: ALURes = {{(WIDTH-1){1'b0}}, (in1 < in2)};
      OP_SUB:  ALURes = in1 - in2;
      OP_SLT:  ALURes = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      OP_SLL:  ALURes = in2 << shamt;
      OP_SRL:  ALURes = in2 >> shamt;
      OP_SRA:  ALURes = b_s >>> shamt;
      OP_MULT: ALURes = prod[2*WIDTH-1:WIDTH];
`ifdef ALU_DIV_EN
      OP_DIV:  ALURes = div_rem;
`endif
      OP_MFHI: ALURes = hi_q;
      OP_MFLO: ALURes = lo_q;
      default: ALURes = '0;
    endcase
  end

  // HI/LO hold the last MULT/DIV result; reset wins over a same-cycle load.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (mult_op) begin
      hi_q <= prod[2*WIDTH-1:WIDTH];
      lo_q <= prod[WIDTH-1:0];
`ifdef ALU_DIV_EN
    end else if (div_op) begin
      hi_q <= div_rem;
      lo_q <= div_quo;
`endif
    end
  end

  assign lo   = lo_q;
  assign zero = (ALURes == '0);

endmodule

// File: tb/tb_alu.sv
// Directed testbench for alu: combinational ops, shifts, MULT/DIV into HI/LO,
// reset priority and undefined opcodes. DIV vectors are built only with ALU_DIV_EN.
module tb_alu;

  logic        clk;
  logic        reset;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [3:0]  ALUCtr;
  logic [31:0] ALURes;
  logic [31:0] lo;
  logic        zero;

  int n_cmp;
  int n_bad;

  alu #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .in1    (in1),
    .in2    (in2),
    .ALUCtr (ALUCtr),
    .ALURes (ALURes),
    .lo     (lo),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs on the falling edge and settle before sampling.
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    @(negedge clk);
    in1    = a;
    in2    = b;
    ALUCtr = op;
    #1;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    reset  = 1'b1;
    in1    = '0;
    in2    = '0;
    ALUCtr = 4'b1111;
    edge_wait();
    edge_wait();
    @(negedge clk);
    reset = 1'b0;

    // Reset state and SUB giving zero
    drive(32'd6, 32'd6, 4'b0110);
    check("sub_eq_res", ALURes, 32'd0);
    check("sub_eq_zero", {31'd0, zero}, 32'd1);
    check("reset_lo", lo, 32'd0);

    // Basic ops with A=6, B=11
    drive(32'd6, 32'd11, 4'b0010);
    check("add", ALURes, 32'd17);
    check("add_zero", {31'd0, zero}, 32'd0);
    drive(32'd6, 32'd11, 4'b0110);
    check("sub", ALURes, 32'hFFFF_FFFB);
    check("sub_zero", {31'd0, zero}, 32'd0);
    drive(32'd6, 32'd11, 4'b0000);
    check("and", ALURes, 32'd2);
    drive(32'd6, 32'd11, 4'b0001);
    check("or", ALURes, 32'd15);
    drive(32'd6, 32'd11, 4'b0100);
    check("xor", ALURes, 32'd13);
    drive(32'd6, 32'd11, 4'b0111);
    check("slt", ALURes, 32'd1);
    drive(32'd6, 32'd11, 4'b0101);
    check("sltu", ALURes, 32'd1);
    // Signed vs unsigned compare disagree on a negative operand
    drive(32'hFFFF_FFFF, 32'd1, 4'b0111);
    check("slt_neg", ALURes, 32'd1);
    drive(32'hFFFF_FFFF, 32'd1, 4'b0101);
    check("sltu_big", ALURes, 32'd0);

    // Shifts
    drive(32'd6, 32'd11, 4'b1000);
    check("sll", ALURes, 32'h0000_02C0);
    drive(32'd6, 32'd11, 4'b1001);
    check("srl", ALURes, 32'd0);
    drive(32'd6, 32'd11, 4'b1010);
    check("sra", ALURes, 32'd0);
    drive(32'd4, 32'h8000_0000, 4'b1010);
    check("sra_neg", ALURes, 32'hF800_0000);
    drive(32'd4, 32'h8000_0000, 4'b1001);
    check("srl_neg", ALURes, 32'h0800_0000);
    // Upper shift-amount bits ignored: 0x24 -> shift by 4
    drive(32'h0000_0024, 32'h8000_0000, 4'b1001);
    check("srl_amt_mask", ALURes, 32'h0800_0000);

    // MULT 6*11
    drive(32'd6, 32'd11, 4'b1011);
    check("mult_res", ALURes, 32'd0);
    check("mult_lo_before", lo, 32'd0);
    edge_wait();
    check("mult_lo", lo, 32'd66);
    drive(32'd6, 32'd11, 4'b1101);
    check("mfhi_66", ALURes, 32'd0);
    check("mfhi_66_zero", {31'd0, zero}, 32'd1);
    drive(32'd6, 32'd11, 4'b1110);
    check("mflo_66", ALURes, 32'd66);

    // MULT -1*2
    drive(32'hFFFF_FFFF, 32'd2, 4'b1011);
    check("mult_neg_res", ALURes, 32'hFFFF_FFFF);
    edge_wait();
    check("mult_neg_lo", lo, 32'hFFFF_FFFE);
    drive(32'd0, 32'd0, 4'b1101);
    check("mfhi_neg", ALURes, 32'hFFFF_FFFF);

`ifdef ALU_DIV_EN
    drive(32'd6, 32'd11, 4'b1100);
    check("div_res", ALURes, 32'd6);
    edge_wait();
    check("div_lo", lo, 32'd0);
    drive(32'hFFFF_FFF9, 32'd2, 4'b1100);
    check("div_neg_res", ALURes, 32'hFFFF_FFFF);
    edge_wait();
    check("div_neg_lo", lo, 32'hFFFF_FFFD);
    drive(32'hFFFF_FFF9, 32'd0, 4'b1100);
    check("div0_res", ALURes, 32'hFFFF_FFF9);
    edge_wait();
    check("div0_lo", lo, 32'hFFFF_FFFF);
    drive(32'd0, 32'd0, 4'b1101);
    check("div0_mfhi", ALURes, 32'hFFFF_FFF9);
    drive(32'h8000_0000, 32'hFFFF_FFFF, 4'b1100);
    check("div_ovf_res", ALURes, 32'd0);
    edge_wait();
    check("div_ovf_lo", lo, 32'h8000_0000);
    drive(32'd0, 32'd0, 4'b1101);
    check("div_ovf_mfhi", ALURes, 32'd0);
    // Load a known pair for the unchanged-state checks below: -1*2
    drive(32'hFFFF_FFFF, 32'd2, 4'b1011);
    edge_wait();
`else
    // Divider not built: 1100 is undefined
    drive(32'd6, 32'd11, 4'b1100);
    check("div_off_res", ALURes, 32'd0);
    check("div_off_zero", {31'd0, zero}, 32'd1);
    edge_wait();
    check("div_off_lo", lo, 32'hFFFF_FFFE);
    drive(32'd0, 32'd0, 4'b1101);
    check("div_off_mfhi", ALURes, 32'hFFFF_FFFF);
`endif

    // Opcode 1111 leaves HI/LO alone across edges
    drive(32'd6, 32'd11, 4'b1111);
    check("op15_res", ALURes, 32'd0);
    check("op15_zero", {31'd0, zero}, 32'd1);
    edge_wait();
    edge_wait();
    check("op15_lo", lo, 32'hFFFF_FFFE);
    drive(32'd0, 32'd0, 4'b1101);
    check("op15_mfhi", ALURes, 32'hFFFF_FFFF);

    // Reset beats a same-cycle MULT
    drive(32'd6, 32'd11, 4'b1011);
    reset = 1'b1;
    #1;
    check("rst_mult_res", ALURes, 32'd0);
    edge_wait();
    check("rst_mult_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(32'd0, 32'd0, 4'b1101);
    check("rst_mult_mfhi", ALURes, 32'd0);
    check("rst_mult_zero", {31'd0, zero}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
